// File: rtl/demux1to4_reg.sv
// demux1to4_reg: steers each input word into one of four one-entry channel registers and counts drains per channel.
// Latency: 1 cycle from input acceptance to out_valid on the selected channel.
// Backpressure: in_ready drops only when the selected channel is full and not draining; there is no head-of-line bypass.
module demux1to4_reg #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic [1:0]      in_sel,
    output logic [3:0]      out_valid,
    input  logic [3:0]      out_ready,
    output logic [4*DW-1:0] out_data,
    output logic [31:0]     cnt_ch
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_t;

    ch_state_t     state_q [4];
    ch_state_t     state_d [4];
    logic [DW-1:0] data_q  [4];
    logic [7:0]    cnt_q   [4];
    logic [3:0]    ld_vld;
    logic [3:0]    drn_vld;

    // A full channel can still take a word on the same edge it is drained.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            in_ready = (state_q[in_sel] == EMPTY) || out_ready[in_sel];
        end
    end

    always_comb begin
        ld_vld  = '0;
        drn_vld = '0;
        for (int k = 0; k < 4; k++) begin
            ld_vld[k]  = in_valid && in_ready && (in_sel == 2'(k));
            drn_vld[k] = (state_q[k] == FULL) && out_ready[k];
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            state_d[k] = state_q[k];
            if (ld_vld[k]) begin
                state_d[k] = FULL;
            end else if (drn_vld[k]) begin
                state_d[k] = EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
                cnt_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= state_d[k];
                if (ld_vld[k]) begin
                    data_q[k] <= in_data;
                end
                if (drn_vld[k]) begin
                    cnt_q[k] <= cnt_q[k] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        out_valid = '0;
        out_data  = '0;
        cnt_ch    = '0;
        for (int k = 0; k < 4; k++) begin
            out_valid[k]           = (state_q[k] == FULL);
            out_data[k*DW +: DW]   = data_q[k];
            cnt_ch[8*k +: 8]       = cnt_q[k];
        end
    end

endmodule

// File: tb/tb_demux1to4_reg.sv
// Bench for demux1to4_reg: directed vector table, hand-written corner sequences and a queue-based random scoreboard.
module tb_demux1to4_reg;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [31:0] cnt_ch;

    int n_checks = 0;
    int n_errors = 0;

    demux1to4_reg #(.DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cnt_ch    (cnt_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        vld;
        logic [1:0]  sel;
        logic [7:0]  dat;
        logic [3:0]  ordy;
        logic        exp_rdy;
        logic [3:0]  exp_vld;
        logic [31:0] exp_data;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic apply(input logic r, input logic v, input logic [1:0] s,
                         input logic [7:0] d, input logic [3:0] o);
        rst_n     = r;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = o;
    endtask

    logic [7:0] q [4][$];
    logic [7:0] mcnt [4];
    logic       exp_rdy;

    initial begin
        apply(1'b0, 1'b0, 2'd0, 8'h00, 4'h0);

        //            rst  vld  sel    dat    ordy   rdy   vld    data           cnt
        vecs[0] = '{1'b0, 1'b1, 2'd0, 8'hFF, 4'h0, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000};
        vecs[1] = '{1'b1, 1'b1, 2'd2, 8'hA5, 4'h0, 1'b1, 4'h4, 32'h00A5_0000, 32'h0000_0000};
        vecs[2] = '{1'b1, 1'b1, 2'd2, 8'h5A, 4'h0, 1'b0, 4'h4, 32'h00A5_0000, 32'h0000_0000};
        vecs[3] = '{1'b1, 1'b0, 2'd2, 8'h77, 4'hF, 1'b1, 4'h0, 32'h00A5_0000, 32'h0001_0000};
        vecs[4] = '{1'b1, 1'b1, 2'd1, 8'h11, 4'h0, 1'b1, 4'h2, 32'h00A5_1100, 32'h0001_0000};
        vecs[5] = '{1'b1, 1'b1, 2'd1, 8'h22, 4'h2, 1'b1, 4'h2, 32'h00A5_2200, 32'h0001_0100};
        vecs[6] = '{1'b1, 1'b0, 2'd1, 8'h33, 4'h1, 1'b0, 4'h2, 32'h00A5_2200, 32'h0001_0100};
        vecs[7] = '{1'b1, 1'b1, 2'd0, 8'h44, 4'h2, 1'b1, 4'h1, 32'h00A5_2244, 32'h0001_0200};
        vecs[8] = '{1'b1, 1'b1, 2'd3, 8'h99, 4'h0, 1'b1, 4'h9, 32'h99A5_2244, 32'h0001_0200};

        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            apply(vecs[i].rst_n, vecs[i].vld, vecs[i].sel, vecs[i].dat, vecs[i].ordy);
            #1;
            check($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].exp_rdy});
            @(negedge clk);
            check($sformatf("vec%0d out_valid", i), {28'd0, out_valid}, {28'd0, vecs[i].exp_vld});
            check($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_data);
            check($sformatf("vec%0d cnt_ch", i), cnt_ch, vecs[i].exp_cnt);
        end

        // Drain channel 3, then hold a stalled word on channel 0 for five cycles.
        apply(1'b1, 1'b0, 2'd0, 8'h00, 4'h8);
        @(negedge clk);
        check("drain3 out_valid", {28'd0, out_valid}, 32'h1);
        check("drain3 cnt_ch", cnt_ch, 32'h0101_0200);
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b1, 2'd0, 8'hEE, 4'h0);
            #1;
            check($sformatf("stall%0d in_ready", i), {31'd0, in_ready}, 32'h0);
            @(negedge clk);
            check($sformatf("stall%0d ch0 data", i), {24'd0, out_data[7:0]}, 32'h44);
            check($sformatf("stall%0d out_valid", i), {28'd0, out_valid}, 32'h1);
        end
        apply(1'b1, 1'b1, 2'd3, 8'hC3, 4'h0);
        #1;
        check("unstall in_ready", {31'd0, in_ready}, 32'h1);
        @(negedge clk);
        check("unstall out_valid", {28'd0, out_valid}, 32'h9);
        check("unstall out_data", out_data, 32'hC3A5_2244);

        // Fill all four channels, then reset while every sink is ready.
        apply(1'b1, 1'b1, 2'd1, 8'hB1, 4'h0);
        @(negedge clk);
        apply(1'b1, 1'b1, 2'd2, 8'hB2, 4'h0);
        @(negedge clk);
        check("full out_valid", {28'd0, out_valid}, 32'hF);
        apply(1'b0, 1'b1, 2'd0, 8'h12, 4'hF);
        #1;
        check("rst in_ready", {31'd0, in_ready}, 32'h0);
        @(negedge clk);
        check("rst out_valid", {28'd0, out_valid}, 32'h0);
        check("rst out_data", out_data, 32'h0);
        check("rst cnt_ch", cnt_ch, 32'h0);
        apply(1'b1, 1'b0, 2'd0, 8'h00, 4'h0);
        #1;
        check("post-rst in_ready", {31'd0, in_ready}, 32'h1);
        @(negedge clk);

        // 257 cycles of load+drain on channel 3 give exactly 256 drains.
        for (int i = 0; i <= 256; i++) begin
            logic [8:0] iv;
            iv = 9'(i);
            apply(1'b1, 1'b1, 2'd3, iv[7:0], 4'h8);
            #1;
            if (in_ready !== 1'b1) check($sformatf("wrap%0d in_ready", i), {31'd0, in_ready}, 32'h1);
            @(negedge clk);
            if (i == 255) check("wrap cnt 255", cnt_ch, 32'hFF00_0000);
        end
        check("wrap cnt 0", cnt_ch, 32'h0000_0000);
        check("wrap out_valid", {28'd0, out_valid}, 32'h8);
        check("wrap ch3 data", {24'd0, out_data[31:24]}, 32'h00);

        apply(1'b0, 1'b0, 2'd0, 8'h00, 4'h0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            q[k].delete();
            mcnt[k] = 8'd0;
        end

        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("rnd%0d vld%0d", cyc, k), {31'd0, out_valid[k]},
                      {31'd0, (q[k].size() != 0)});
                if (q[k].size() != 0)
                    check($sformatf("rnd%0d data%0d", cyc, k), {24'd0, out_data[8*k +: 8]}, {24'd0, q[k][0]});
                check($sformatf("rnd%0d cnt%0d", cyc, k), {24'd0, cnt_ch[8*k +: 8]}, {24'd0, mcnt[k]});
            end
            apply(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
            #1;
            exp_rdy = (q[in_sel].size() == 0) || out_ready[in_sel];
            check($sformatf("rnd%0d in_ready", cyc), {31'd0, in_ready}, {31'd0, exp_rdy});
            for (int k = 0; k < 4; k++) begin
                if (q[k].size() != 0 && out_ready[k]) begin
                    void'(q[k].pop_front());
                    mcnt[k] = mcnt[k] + 8'd1;
                end
            end
            if (in_valid && exp_rdy) q[in_sel].push_back(in_data);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
